// File: rtl/mnist_score_argmax.sv
// Per-class frame accumulator with a sequential ten-cycle argmax over the totals.
// Optional build macro SCORE_BIAS_EN adds the per-class bias B_k to each total before the compare.
module mnist_score_argmax #(
    parameter int DEBIT      = 22,
    parameter int NUM_BLOCKS = 784,
    parameter int ACC_W      = 33,
    parameter logic signed [ACC_W-1:0] B_0 = '0,
    parameter logic signed [ACC_W-1:0] B_1 = '0,
    parameter logic signed [ACC_W-1:0] B_2 = '0,
    parameter logic signed [ACC_W-1:0] B_3 = '0,
    parameter logic signed [ACC_W-1:0] B_4 = '0,
    parameter logic signed [ACC_W-1:0] B_5 = '0,
    parameter logic signed [ACC_W-1:0] B_6 = '0,
    parameter logic signed [ACC_W-1:0] B_7 = '0,
    parameter logic signed [ACC_W-1:0] B_8 = '0,
    parameter logic signed [ACC_W-1:0] B_9 = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_start,
    input  logic                    res_done,
    input  logic signed [DEBIT:0]   score_0,
    input  logic signed [DEBIT:0]   score_1,
    input  logic signed [DEBIT:0]   score_2,
    input  logic signed [DEBIT:0]   score_3,
    input  logic signed [DEBIT:0]   score_4,
    input  logic signed [DEBIT:0]   score_5,
    input  logic signed [DEBIT:0]   score_6,
    input  logic signed [DEBIT:0]   score_7,
    input  logic signed [DEBIT:0]   score_8,
    input  logic signed [DEBIT:0]   score_9,
    output logic [3:0]              digit,
    output logic signed [ACC_W-1:0] max_score,
    output logic                    digit_valid,
    output logic                    busy,
    output logic [9:0]              blk_cnt,
    output logic                    overrun
);

    typedef enum logic [1:0] {IDLE, ACCUM, ARGMAX, DONE} state_t;

`ifdef SCORE_BIAS_EN
    localparam bit BIAS_EN = 1'b1;
`else
    localparam bit BIAS_EN = 1'b0;
`endif

    localparam logic signed [ACC_W-1:0] BIAS [10] =
        '{B_0, B_1, B_2, B_3, B_4, B_5, B_6, B_7, B_8, B_9};

    state_t                  state_reg;
    logic signed [DEBIT:0]   score [10];
    logic signed [ACC_W-1:0] acc_reg [10];
    logic signed [ACC_W-1:0] best_reg;
    logic signed [ACC_W-1:0] cand;
    logic [3:0]              idx_reg;
    logic [3:0]              best_idx_reg;
    logic [3:0]              digit_reg;
    logic signed [ACC_W-1:0] max_score_reg;
    logic                    digit_valid_reg;
    logic                    busy_reg;
    logic [9:0]              blk_cnt_reg;
    logic                    overrun_reg;
    logic                    restart;

    assign score[0] = score_0;
    assign score[1] = score_1;
    assign score[2] = score_2;
    assign score[3] = score_3;
    assign score[4] = score_4;
    assign score[5] = score_5;
    assign score[6] = score_6;
    assign score[7] = score_7;
    assign score[8] = score_8;
    assign score[9] = score_9;

    // With the bias disabled the addend is a constant zero and the adder folds away.
    always_comb begin
        cand = acc_reg[idx_reg] + (BIAS_EN ? BIAS[idx_reg] : '0);
    end

    // A frame_start seen in DONE is deliberately ignored; it only counts if still high in IDLE.
    assign restart = frame_start && (state_reg != DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            for (int k = 0; k < 10; k++) acc_reg[k] <= '0;
            best_reg        <= '0;
            idx_reg         <= '0;
            best_idx_reg    <= '0;
            digit_reg       <= '0;
            max_score_reg   <= '0;
            digit_valid_reg <= 1'b0;
            busy_reg        <= 1'b0;
            blk_cnt_reg     <= '0;
            overrun_reg     <= 1'b0;
        end else begin
            digit_valid_reg <= 1'b0;
            if (restart) begin
                for (int k = 0; k < 10; k++) acc_reg[k] <= '0;
                blk_cnt_reg <= '0;
                overrun_reg <= 1'b0;
                idx_reg     <= '0;
                state_reg   <= ACCUM;
                busy_reg    <= 1'b1;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (res_done) overrun_reg <= 1'b1;
                    end
                    ACCUM: begin
                        if (res_done) begin
                            for (int k = 0; k < 10; k++)
                                acc_reg[k] <= acc_reg[k] + ACC_W'(score[k]);
                            blk_cnt_reg <= blk_cnt_reg + 10'd1;
                            if (blk_cnt_reg == 10'(NUM_BLOCKS - 1)) begin
                                idx_reg   <= '0;
                                state_reg <= ARGMAX;
                            end
                        end
                    end
                    ARGMAX: begin
                        if (res_done) overrun_reg <= 1'b1;
                        // Strict greater-than keeps the lower index on a tie.
                        if (idx_reg == 4'd0 || cand > best_reg) begin
                            best_reg     <= cand;
                            best_idx_reg <= idx_reg;
                        end
                        if (idx_reg == 4'd9) begin
                            idx_reg   <= '0;
                            state_reg <= DONE;
                        end else begin
                            idx_reg <= idx_reg + 4'd1;
                        end
                    end
                    DONE: begin
                        if (res_done) overrun_reg <= 1'b1;
                        digit_reg       <= best_idx_reg;
                        max_score_reg   <= best_reg;
                        digit_valid_reg <= 1'b1;
                        busy_reg        <= 1'b0;
                        state_reg       <= IDLE;
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign digit       = digit_reg;
    assign max_score   = max_score_reg;
    assign digit_valid = digit_valid_reg;
    assign busy        = busy_reg;
    assign blk_cnt     = blk_cnt_reg;
    assign overrun     = overrun_reg;

endmodule

// File: tb/tb_mnist_score_argmax.sv
// Randomized and directed frames for mnist_score_argmax checked against a plain sum-and-argmax model.
module tb_mnist_score_argmax;

    localparam int DEBIT = 22;
    localparam int NB    = 4;
    localparam int ACC_W = 33;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    frame_start = 1'b0;
    logic                    res_done = 1'b0;
    logic signed [DEBIT:0]   sc [10];
    logic [3:0]              digit;
    logic signed [ACC_W-1:0] max_score;
    logic                    digit_valid;
    logic                    busy;
    logic [9:0]              blk_cnt;
    logic                    overrun;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    pat [10];
    longint sum [10];
    longint bias [10];
    int    frame_no = 0;

    always #5 clk = ~clk;

    mnist_score_argmax #(
        .DEBIT(DEBIT), .NUM_BLOCKS(NB), .ACC_W(ACC_W), .B_4(33'sd1000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .res_done(res_done),
        .score_0(sc[0]), .score_1(sc[1]), .score_2(sc[2]), .score_3(sc[3]), .score_4(sc[4]),
        .score_5(sc[5]), .score_6(sc[6]), .score_7(sc[7]), .score_8(sc[8]), .score_9(sc[9]),
        .digit(digit), .max_score(max_score), .digit_valid(digit_valid), .busy(busy),
        .blk_cnt(blk_cnt), .overrun(overrun)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pat();
        for (int k = 0; k < 10; k++) sc[k] = DEBIT'(pat[k]);
    endtask

    task automatic clear_model();
        for (int k = 0; k < 10; k++) sum[k] = 0;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        clear_model();
    endtask

    // One res_done strobe carrying pat[]; with fs set the strobe coincides with a restart.
    task automatic strobe(input bit fs);
        drive_pat();
        res_done    = 1'b1;
        frame_start = fs;
        step();
        res_done    = 1'b0;
        frame_start = 1'b0;
        if (fs) clear_model();
        else for (int k = 0; k < 10; k++) sum[k] += pat[k];
    endtask

    task automatic expect_result(input string tag);
        longint best;
        int     best_i;
        int     lat;
        best   = sum[0] + bias[0];
        best_i = 0;
        for (int i = 1; i < 10; i++)
            if (sum[i] + bias[i] > best) begin
                best   = sum[i] + bias[i];
                best_i = i;
            end
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (digit_valid) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, lat, 11);
        check({tag, "_digit"}, digit, best_i);
        check({tag, "_max"}, max_score, best);
        check({tag, "_busy"}, busy, 0);
        $display("frame %0d %s: digit=%0d max_score=%0d (model %0d/%0d) latency=%0d",
                 frame_no, tag, digit, max_score, best_i, best, lat);
        frame_no++;
        step();
        check({tag, "_pulse"}, digit_valid, 0);
        check({tag, "_hold"}, digit, best_i);
    endtask

    task automatic const_frame(input string tag);
        start_frame();
        for (int b = 0; b < NB; b++) strobe(1'b0);
        expect_result(tag);
    endtask

    initial begin
        for (int k = 0; k < 10; k++) begin
            bias[k] = 0;
            pat[k]  = 0;
        end
`ifdef SCORE_BIAS_EN
        bias[4] = 1000;
`endif
        drive_pat();
        #12;
        check("rst_digit", digit, 0);
        check("rst_max", max_score, 0);
        check("rst_valid", digit_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_blk_cnt", blk_cnt, 0);
        check("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        step();

        // All-zero scores: only the bias (if enabled) can win, otherwise class 0.
        const_frame("zero_bias");

        for (int k = 0; k < 10; k++) pat[k] = 0;
        pat[7] = 100;
        start_frame();
        check("start_busy", busy, 1);
        for (int b = 0; b < NB; b++) strobe(1'b0);
        check("full_blk_cnt", blk_cnt, NB);
        expect_result("class7");

        for (int k = 0; k < 10; k++) pat[k] = 0;
        pat[2] = 50;
        pat[5] = 50;
        const_frame("tie");

        for (int k = 0; k < 10; k++) pat[k] = -10;
        pat[3] = -1;
        const_frame("negative");

        // Overrun from a strobe in IDLE, cleared by the next frame_start.
        pat[0] = 12345;
        strobe(1'b0);
        clear_model();
        check("overrun_set", overrun, 1);
        check("overrun_idle_busy", busy, 0);
        start_frame();
        check("overrun_clear", overrun, 0);
        check("overrun_blk_cnt", blk_cnt, 0);

        // Restart coincident with the third strobe discards the partial frame.
        for (int k = 0; k < 10; k++) pat[k] = int'($urandom_range(2000)) - 1000;
        strobe(1'b0);
        strobe(1'b0);
        strobe(1'b1);
        check("abort_blk_cnt", blk_cnt, 0);
        check("abort_valid", digit_valid, 0);
        check("abort_busy", busy, 1);
        for (int b = 0; b < NB; b++) begin
            for (int k = 0; k < 10; k++) pat[k] = int'($urandom_range(2000)) - 1000;
            strobe(1'b0);
        end
        expect_result("after_abort");

        // Random frames with random idle gaps between strobes.
        for (int f = 0; f < 20; f++) begin
            start_frame();
            for (int b = 0; b < NB; b++) begin
                for (int k = 0; k < 10; k++) pat[k] = int'($urandom_range(200000)) - 100000;
                repeat ($urandom_range(2)) step();
                strobe(1'b0);
            end
            expect_result("random");
        end

        // Asynchronous reset mid-frame clears the outputs immediately.
        start_frame();
        strobe(1'b0);
        strobe(1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_blk_cnt", blk_cnt, 0);
        check("midrst_busy", busy, 0);
        check("midrst_digit", digit, 0);
        check("midrst_max", max_score, 0);
        rst_n = 1'b1;
        step();
        step();
        check("midrst_valid", digit_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mnist_score_argmax.md
# mnist_score_argmax

Collects the per-block weighted score contributions produced by the 28×28 pixel-block scorers and turns them into a single classified digit. Sits downstream of the block array: each `res_done` strobe delivers one block's ten signed partial scores. The block sums these per class over one frame, optionally adds per-class biases, then runs a sequential argmax. It reports the winning digit and its score with a one-cycle valid pulse.

## Interface
- `DEBIT`, 22: MSB index of each incoming signed score (score width DEBIT+1).
- `NUM_BLOCKS`, 784: `res_done` strobes expected per frame. Legal range 1..1023.
- `ACC_W`, 33: per-class accumulator width. Must be ≥ DEBIT+1+ceil(log2(NUM_BLOCKS)).
- `B_0` … `B_9`, 0: signed per-class bias, ACC_W bits. Used only with `SCORE_BIAS_EN`.

- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `frame_start`  in  1  one-cycle pulse: clear accumulators, begin a new frame
- `res_done`  in  1  one-cycle strobe: `score_0..9` valid this cycle
- `score_0` … `score_9`  in  DEBIT+1 each  signed partial score from one block
- `digit`  out  4  winning class 0..9
- `max_score`  out  ACC_W  signed final score of the winning class
- `digit_valid`  out  1  one-cycle pulse when `digit`/`max_score` update
- `busy`  out  1  high in ACCUM, ARGMAX and DONE
- `blk_cnt`  out  10  strobes accepted in the current frame
- `overrun`  out  1  sticky: `res_done` seen outside ACCUM; cleared by `frame_start`

## Operation
- States: IDLE, ACCUM, ARGMAX, DONE.
- IDLE
  - `frame_start` clears `acc_0..9`, `blk_cnt` and `overrun`, then moves to ACCUM.
  - `res_done` is ignored for accumulation and sets `overrun`. If `frame_start` arrives in the same cycle, `frame_start` wins and `overrun` stays clear.
- ACCUM, on `res_done`:
  - `acc_k <= acc_k + sign_extend(score_k)` for k = 0..9.
  - `blk_cnt` increments.
  - The strobe that makes `blk_cnt == NUM_BLOCKS` moves the FSM to ARGMAX.
- ACCUM, on `frame_start` (with or without `res_done` in the same cycle):
  - Restart: accumulators and `blk_cnt` cleared, partial frame discarded, stay in ACCUM.
  - No `digit_valid` is produced for the discarded frame.
- ARGMAX: one class per cycle, index i = 0..9, 10 cycles total.
  - i = 0 loads best = `acc_0` (+`B_0`) and best_idx = 0.
  - i = 1..9 replace best only if `acc_i` (+`B_i`) > best, compared as signed. Ties therefore go to the lower index.
  - `frame_start` aborts the argmax and goes to ACCUM cleared. Outputs are not updated.
  - `res_done` sets `overrun`.
- DONE: one cycle.
  - Register `digit` <= best_idx and `max_score` <= best; pulse `digit_valid`.
  - Return to IDLE. `frame_start` arriving in DONE is honoured on the following IDLE cycle only if it is still asserted; otherwise it is lost.
- Arithmetic: all two's-complement, wrap on overflow, no saturation. Legal parameters guarantee no overflow.
- `digit` and `max_score` hold their values until the next `digit_valid` or reset.

## Timing
- Reset (async assert, sync release):
  - State IDLE; all accumulators 0.
  - `digit`=0, `max_score`=0, `digit_valid`=0, `busy`=0, `blk_cnt`=0, `overrun`=0.
- Reset mid-frame or mid-argmax discards everything; no output pulse.
- Latency: final `res_done` sampled at edge T; ARGMAX occupies edges T+1..T+10; `digit_valid` is high in the cycle following edge T+11.
- Back-to-back `res_done` on every cycle is supported in ACCUM.
- `busy` is registered and follows the state register.
- NUM_BLOCKS=1: the first accepted strobe moves directly to ARGMAX.

## Configuration
- `SCORE_BIAS_EN` defined: `B_k` is added to `acc_k` in the ARGMAX compare path, and `max_score` includes the bias.
- `SCORE_BIAS_EN` undefined: no adders in the compare path, `B_k` parameters unused, compare uses raw `acc_k`.

## Test plan
- NUM_BLOCKS=4, four strobes with all scores 0 except `score_7`=100 → `digit`=7, `max_score`=400, `digit_valid` 11 cycles after the last strobe.
- Tie: `score_2`=`score_5`=50 on every strobe, others 0 → `digit`=2.
- Negative: all classes -10 except `score_3`=-1, NUM_BLOCKS=4 → `digit`=3, `max_score`=-4.
- `frame_start` coincident with the 3rd of 4 strobes → `blk_cnt`=0, no `digit_valid`; four fresh strobes then classify correctly.
- `res_done` in IDLE → `overrun`=1, accumulators untouched; next `frame_start` → `overrun`=0.
- `SCORE_BIAS_EN` with `B_4`=1000, all scores 0 → `digit`=4, `max_score`=1000. Without the macro → `digit`=0, `max_score`=0.
